// File: rtl/ex_stage_pkg.sv
// Shared widths, field layouts and bit indices for the execute stage.
// Imported by the stage, its ALU and the SRAM interface.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam int SRC1_RS = 0;
  localparam int SRC1_PC = 1;
  localparam int SRC1_SA = 2;

  localparam int SRC2_RT  = 0;
  localparam int SRC2_SIM = 1;
  localparam int SRC2_8   = 2;
  localparam int SRC2_ZIM = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } fwd_t;

endpackage

// File: rtl/ex_stage_if.sv
// Data-SRAM request bus driven by the execute stage.
// The stage is master; the memory side is slave.
interface ex_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata
  );

  modport slave (
    input data_sram_en,
    input data_sram_wen,
    input data_sram_addr,
    input data_sram_wdata
  );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational ALU: result is the OR of every enabled op result,
// so an all-zero alu_op yields zero.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  logic [4:0] sa;
  assign sa = src1[4:0];

  always_comb begin
    result = '0;
    if (alu_op[ALU_ADD])
      result |= src1 + src2;
    if (alu_op[ALU_SUB])
      result |= src1 - src2;
    if (alu_op[ALU_SLT])
      result |= {31'b0, $signed(src1) < $signed(src2)};
    if (alu_op[ALU_SLTU])
      result |= {31'b0, src1 < src2};
    if (alu_op[ALU_AND])
      result |= src1 & src2;
    if (alu_op[ALU_NOR])
      result |= ~(src1 | src2);
    if (alu_op[ALU_OR])
      result |= src1 | src2;
    if (alu_op[ALU_XOR])
      result |= src1 ^ src2;
    if (alu_op[ALU_SLL])
      result |= src2 << sa;
    if (alu_op[ALU_SRL])
      result |= src2 >> sa;
    if (alu_op[ALU_SRA])
      result |= 32'($signed(src2) >>> sa);
    if (alu_op[ALU_LUI])
      result |= {src2[15:0], 16'h0};
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: input register, operand select, ALU, data-SRAM
// request, forwarding bus and load-use stall request.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id,
  output logic                    stallreq_for_ex,
  ex_stage_if.master              sram
);

  id_ex_t      r;
  ex_mem_t     mem;
  fwd_t        fwd;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] result;
  logic        mem_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r <= '0;
    else if (stall[ST_EX] == STOP && stall[ST_MEM] == NO_STOP)
      r <= '0;
    else if (stall[ST_EX] == NO_STOP)
      r <= id_ex_t'(id_to_ex_bus);
  end

  always_comb begin
    src1 = '0;
    unique case (1'b1)
      r.sel_src1[SRC1_RS]: src1 = r.rs_val;
      r.sel_src1[SRC1_PC]: src1 = r.pc;
      r.sel_src1[SRC1_SA]: src1 = {27'b0, r.inst[10:6]};
      default:             src1 = '0;
    endcase
  end

  always_comb begin
    src2 = '0;
    unique case (1'b1)
      r.sel_src2[SRC2_RT]:  src2 = r.rt_val;
      r.sel_src2[SRC2_SIM]: src2 = {{16{r.inst[15]}}, r.inst[15:0]};
      r.sel_src2[SRC2_8]:   src2 = 32'd8;
      r.sel_src2[SRC2_ZIM]: src2 = {16'b0, r.inst[15:0]};
      default:              src2 = '0;
    endcase
  end

  ex_stage_alu u_alu (
    .alu_op (r.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (result)
  );

  always_comb begin
    mem            = '0;
    mem.pc         = r.pc;
    mem.ram_en     = r.ram_en;
    mem.ram_wen    = r.ram_wen;
    mem.sel_rf_res = r.sel_rf_res;
    mem.rf_we      = r.rf_we;
    mem.rf_waddr   = r.rf_waddr;
    mem.ex_result  = result;
  end

  // Load data only exists after MEM, so loads request a stall
  // instead of forwarding.
  always_comb begin
    fwd       = '0;
    fwd.we    = r.rf_we & ~r.sel_rf_res;
    fwd.waddr = r.rf_waddr;
    fwd.wdata = result;
  end

  assign ex_to_mem_bus   = mem;
  assign ex_to_id        = fwd;
  assign stallreq_for_ex = r.rf_we & r.sel_rf_res;

  // A held EX stage must not repeat its memory request.
  assign mem_go = stall[ST_MEM] == NO_STOP;

  assign sram.data_sram_en    = r.ram_en & mem_go;
  assign sram.data_sram_wen   = sram.data_sram_en ? r.ram_wen : 4'b0;
  assign sram.data_sram_addr  = result;
  assign sram.data_sram_wdata = r.rt_val;

  logic unused_bits;
  assign unused_bits = ^{r.inst[31:16], stall[5:4], stall[1:0]};

endmodule
